pc_seq: RTL
===========

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter XLEN, default 32: PC, immediate and target width.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000: PC value loaded at reset.
REQ-003 Parameter IMM_SHIFT, default 1: left shift applied to imm32 for the branch offset.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Ports:
- inst_valid, input, 1: instruction memory has returned the instruction at pc.
- stall, input, 1: hold the current instruction in EXEC.
- branch, input, 1: current instruction is a conditional branch.
- branch_type, input, 3: funct3 of the branch.
- zero, input, 1: ALU equal flag.
- less, input, 1: ALU less-than flag, signed or unsigned per branch_type.
- jump, input, 1: current instruction is jal/jalr.
- jump_target, input, XLEN: ALU-computed jump address.
- imm32, input, XLEN: sign-extended immediate.
- trap_clr, input, 1: acknowledge a trap.
REQ-007 Ports:
- pc, output, XLEN: address of the current instruction.
- pc_plus4, output, XLEN: pc+4, combinational.
- fetch_req, output, 1: fetch request for pc.
- redirect, output, 1: registered one-cycle pulse on a taken branch or jump.
- trap, output, 1: misaligned-target trap pending.
- trap_pc, output, XLEN: offending target.
- retire_cnt, output, 32: count of retired instructions.

Function
REQ-010 The FSM SHALL have the states IDLE, FETCH, EXEC and TRAP, with the 2-bit encodings 00, 01, 10 and 11.
REQ-011 IDLE SHALL go to FETCH on the first clock edge after rst is released, with fetch_req=0 while in IDLE.
REQ-012 In FETCH, fetch_req SHALL be 1; the FSM SHALL go to EXEC on an edge with inst_valid=1 and SHALL otherwise stay in FETCH with pc held.
REQ-013 In EXEC, when stall=1, the FSM SHALL stay in EXEC with pc, retire_cnt and redirect=0 held.
REQ-014 In EXEC, when stall=0, the block SHALL update pc to next_pc, increment retire_cnt, set redirect to "taken" for one cycle, and go to FETCH.
REQ-015 Branch taken SHALL be decided by branch_type:
- 000 (beq): taken when zero.
- 001 (bne): taken when !zero.
- 100 (blt) and 110 (bltu): taken when less.
- 101 (bge) and 111 (bgeu): taken when !less.
- 010 and 011: never taken.
REQ-016 The branch target SHALL be pc + (imm32 << IMM_SHIFT), truncated to XLEN bits so that it wraps modulo 2^XLEN.
REQ-017 The jump target SHALL be jump_target with bit 0 forced to 0.
REQ-018 Priority SHALL be branch over jump: if branch=1 and jump=1, only the branch rule applies and jump is ignored.
REQ-019 A non-taken instruction SHALL give next_pc = pc_plus4, which wraps from 0xFFFF_FFFC to 0x0000_0000.
REQ-020 Inputs in FETCH and IDLE (branch, jump, stall, imm32) SHALL be ignored.
REQ-021 retire_cnt SHALL wrap from 0xFFFF_FFFF to 0.
REQ-022 The redirect pulse SHALL be high for exactly the one cycle following the EXEC exit edge.

Reset
REQ-030 While rst=1, regardless of clk:
- pc = RESET_VEC.
- state = IDLE.
- fetch_req, redirect and trap = 0.
- trap_pc and retire_cnt = 0.
REQ-031 Reset asserted mid-FETCH, mid-EXEC (including during a stall) or in TRAP SHALL abandon the instruction and SHALL NOT increment retire_cnt.

Configuration
REQ-040 The macro PC_SEQ_TRAP_EN SHALL enable misaligned-target trapping.
REQ-041 With PC_SEQ_TRAP_EN defined, a taken target with target[1:0] != 00 on the EXEC exit SHALL:
- go to TRAP.
- hold pc.
- leave retire_cnt unchanged.
- set trap=1 and trap_pc=target.
- keep redirect=0.
REQ-042 In TRAP, fetch_req SHALL be 0; trap_clr=1 SHALL set pc to pc_plus4, clear trap, increment retire_cnt and go to FETCH.
REQ-043 With PC_SEQ_TRAP_EN undefined:
- target[1:0] SHALL be forced to 00.
- trap and trap_pc SHALL be constant 0.
- TRAP SHALL be unreachable.
- trap_clr SHALL be ignored.

Verification
REQ-050 Reset sequence: with rst=1, then released and inst_valid held 0 for 5 cycles, then 1 → pc=0, fetch_req=0 for 1 cycle then 1, and EXEC is entered only after inst_valid=1.
REQ-051 Branch taken: pc=0x40, branch=1, branch_type=000, zero=1, imm32=0x8 → pc=0x50, redirect=1 for one cycle, retire_cnt+1.
REQ-052 Branch not taken: pc=0x40, branch_type=101, less=1 → pc=0x44, redirect=0.
REQ-053 Branch-over-jump priority: branch=1 and jump=1, jump_target=0x201, bne not taken → pc=pc+4.
REQ-054 Jump in isolation: jump=1 alone, jump_target=0x201 → pc=0x200.
REQ-055 Stall and wraps:
- stall=1 for 3 EXEC cycles → pc and retire_cnt unchanged.
- pc=0xFFFF_FFFC with a non-taken instruction → pc=0.
- retire_cnt forced to 0xFFFF_FFFF, then one retire → 0.
REQ-056 With PC_SEQ_TRAP_EN defined, jump_target=0x102 → trap=1, trap_pc=0x102, pc held; trap_clr=1 → pc=pc+4, trap=0.
REQ-057 With PC_SEQ_TRAP_EN undefined, jump_target=0x102 → pc=0x100, trap=0.

Source files
------------

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer for a simple multi-cycle core.
//
// Walks IDLE -> FETCH -> EXEC -> FETCH ... and computes the next PC from the
// branch/jump inputs presented in the last EXEC cycle. The current FSM state
// is exported on the `state` debug port.
//
// Optional feature: define PC_SEQ_TRAP_EN to trap on taken targets whose
// low two bits are not 00 (TRAP state, trap/trap_pc outputs, trap_clr ack).
// Without it, taken targets are forced word aligned and TRAP is unreachable.
//
// Handshake: fetch_req is the request (valid) for the address on pc; the
// instruction memory answers with inst_valid (ready/response), and the edge
// on which fetch_req=1 and inst_valid=1 are both high moves FETCH to EXEC.
// pc is stable for the whole time fetch_req is high.

module pc_seq #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}},
  parameter int              IMM_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic            stall,
  input  logic            branch,
  input  logic [2:0]      branch_type,
  input  logic            zero,
  input  logic            less,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] imm32,
  input  logic            trap_clr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_req,
  output logic            redirect,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [31:0]     retire_cnt,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_TRAP  = 2'b11
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_retire_cnt;
  logic            r_redirect;
  logic            r_trap;
  logic [XLEN-1:0] r_trap_pc;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [31:0]     w_retire_nxt;
  logic            w_redirect_nxt;
  logic            w_trap_nxt;
  logic [XLEN-1:0] w_trap_pc_nxt;
  logic            w_fetch_req;

  logic [XLEN-1:0] w_pc_plus4;
  logic            w_br_taken;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_jmp_target;
  logic            w_taken;
  logic [XLEN-1:0] w_raw_target;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;
  logic [XLEN-1:0] w_next_pc;

  // Target arithmetic: everything wraps modulo 2^XLEN by truncation.
  assign w_pc_plus4   = r_pc + XLEN'(4);
  assign w_br_target  = r_pc + (imm32 << IMM_SHIFT);
  assign w_jmp_target = jump_target & ~XLEN'(1);

  // Branch condition decode from funct3; 010/011 are never taken.
  always_comb begin
    w_br_taken = 1'b0;
    case (branch_type)
      3'b000:         w_br_taken = zero;
      3'b001:         w_br_taken = ~zero;
      3'b100, 3'b110: w_br_taken = less;
      3'b101, 3'b111: w_br_taken = ~less;
      default:        w_br_taken = 1'b0;
    endcase
  end

  // Branch wins over jump: when branch=1 the jump inputs are not looked at.
  assign w_taken      = branch ? w_br_taken  : jump;
  assign w_raw_target = branch ? w_br_target : w_jmp_target;

`ifdef PC_SEQ_TRAP_EN
  assign w_target     = w_raw_target;
  assign w_misaligned = w_taken && (w_raw_target[1:0] != 2'b00);
`else
  assign w_target     = w_raw_target & ~XLEN'(3);
  assign w_misaligned = 1'b0;
  logic w_unused_trap_clr;
  assign w_unused_trap_clr = trap_clr;
`endif

  assign w_next_pc = w_taken ? w_target : w_pc_plus4;

  // Next-state and next-datapath values; every register holds by default.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_retire_nxt   = r_retire_cnt;
    w_redirect_nxt = 1'b0;
    w_trap_nxt     = r_trap;
    w_trap_pc_nxt  = r_trap_pc;
    w_fetch_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_fetch_req = 1'b1;
        if (inst_valid) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (!stall) begin
          if (w_misaligned) begin
            // Offending instruction does not retire and pc stays on it.
            w_state_nxt   = S_TRAP;
            w_trap_nxt    = 1'b1;
            w_trap_pc_nxt = w_target;
          end else begin
            w_state_nxt    = S_FETCH;
            w_pc_nxt       = w_next_pc;
            w_retire_nxt   = r_retire_cnt + 32'd1;
            w_redirect_nxt = w_taken;
          end
        end
      end
      S_TRAP: begin
`ifdef PC_SEQ_TRAP_EN
        // Acknowledged trap skips the faulting instruction and retires it.
        if (trap_clr) begin
          w_state_nxt  = S_FETCH;
          w_pc_nxt     = w_pc_plus4;
          w_trap_nxt   = 1'b0;
          w_retire_nxt = r_retire_cnt + 32'd1;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_VEC;
      r_retire_cnt <= 32'd0;
      r_redirect   <= 1'b0;
      r_trap       <= 1'b0;
      r_trap_pc    <= {XLEN{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_retire_cnt <= w_retire_nxt;
      r_redirect   <= w_redirect_nxt;
      r_trap       <= w_trap_nxt;
      r_trap_pc    <= w_trap_pc_nxt;
    end
  end

  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign fetch_req  = w_fetch_req;
  assign redirect   = r_redirect;
  assign trap       = r_trap;
  assign trap_pc    = r_trap_pc;
  assign retire_cnt = r_retire_cnt;
  assign state      = r_state;

endmodule
